digit_grid_feature: RTL and testbench

Downstream consumer of the digit bounding-box tracker in the recognition pipeline. Each frame, it latches the Left/Right/Top/Bottom box and splits it into a 4×4 grid. It counts dark pixels and total pixels per cell from the same RGB pixel stream. At a fixed end-of-frame coordinate it emits a 16-bit occupancy feature word for the digit classifier.

---
 rtl/digit_grid_feature_pkg.sv | 22 ++
 rtl/digit_grid_feature_if.sv | 26 ++
 rtl/digit_grid_feature_grid_boundary.sv | 19 +
 rtl/digit_grid_feature.sv | 171 +++++++++++++++++
 tb/tb_digit_grid_feature.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/digit_grid_feature_pkg.sv
// Shared types and constants for the digit grid feature extractor (4x4 occupancy grid).
// Counters saturate instead of wrapping so a huge box can never fake a low dark ratio.
package digit_grid_feature_pkg;

  localparam int GRID_N = 4;
  localparam int CELLS  = GRID_N * GRID_N;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic [7:0]  DARK_TH_DEF = 8'd200;
  localparam logic [10:0] END_X_DEF   = 11'd1220;
  localparam logic [9:0]  END_Y_DEF   = 10'd715;

  typedef enum logic [1:0] {IDLE, SETUP, ACCUM, EVAL} state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/digit_grid_feature_if.sv
// Pixel stream, bounding box and feature result bundle between tracker, extractor and classifier.
// The master drives pixels and the box; the slave (extractor) returns the feature word.
interface digit_grid_feature_if;

  logic [23:0] RGB_Data_Src;
  logic [10:0] RGB_x_Src;
  logic [9:0]  RGB_y_Src;
  logic [10:0] Left;
  logic [10:0] Right;
  logic [9:0]  Top;
  logic [9:0]  Bottom;
  logic [15:0] Feature;
  logic        Feature_Valid;
  logic        Feature_Empty;

  modport master (
    output RGB_Data_Src, RGB_x_Src, RGB_y_Src, Left, Right, Top, Bottom,
    input  Feature, Feature_Valid, Feature_Empty
  );

  modport slave (
    input  RGB_Data_Src, RGB_x_Src, RGB_y_Src, Left, Right, Top, Bottom,
    output Feature, Feature_Valid, Feature_Empty
  );

endinterface

// File: rtl/digit_grid_feature_grid_boundary.sv
// Splits a span starting at origin into four quarters: bnd[k-1] = origin + ((k*span)>>2).
// Purely combinational; the caller registers the result once per frame.
module digit_grid_feature_grid_boundary
  import digit_grid_feature_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0]              origin,
  input  logic [11:0]               span,
  output logic [GRID_N-2:0][W-1:0]  bnd
);

  for (genvar k = 1; k < GRID_N; k++) begin : g_bnd
    logic [13:0] prod;
    assign prod       = 14'(k) * {2'b00, span};
    assign bnd[k-1]   = origin + W'(prod >> 2);
  end

endmodule

// File: rtl/digit_grid_feature.sv
// Per-frame 4x4 dark-pixel occupancy of the tracked digit box; Feature_Valid 2 cycles after END pixel.
// One pixel per clock, no backpressure: the stream is consumed unconditionally.
module digit_grid_feature
  import digit_grid_feature_pkg::*;
#(
  parameter logic [7:0]  DARK_TH = DARK_TH_DEF,
  parameter logic [10:0] END_X   = END_X_DEF,
  parameter logic [9:0]  END_Y   = END_Y_DEF
) (
  input logic               clk,
  input logic               rst,
  digit_grid_feature_if.slave bus
);

  state_t state, state_nxt;
  logic   setup_en, accum_en, eval_en;
  logic   frame_start, frame_end;

  logic [11:0] span_w, span_h;
  logic [GRID_N-2:0][10:0] cb_nxt, cb;
  logic [GRID_N-2:0][9:0]  rb_nxt, rb;
  logic [10:0] left_q, right_q;
  logic [9:0]  top_q, bottom_q;
  logic        empty_q;

  logic [IDX_W-1:0]   col_c, row_c;
  logic               in_box_c;
  logic               s1_vld, s1_dark;
  logic [2*IDX_W-1:0] s1_cell;

  cnt_t             tot_cnt [CELLS];
  cnt_t             drk_cnt [CELLS];
  logic [CELLS-1:0] feat_c;

  logic [15:0] unused_rgb;
  assign unused_rgb = bus.RGB_Data_Src[23:8];

  assign frame_start = (bus.RGB_x_Src == '0) && (bus.RGB_y_Src == '0);
  assign frame_end   = (bus.RGB_x_Src == END_X) && (bus.RGB_y_Src == END_Y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    setup_en  = 1'b0;
    accum_en  = 1'b0;
    eval_en   = 1'b0;
    case (state)
      IDLE:  if (frame_start) state_nxt = SETUP;
      SETUP: begin
        setup_en  = 1'b1;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        accum_en = 1'b1;
        // A new frame start abandons the truncated frame without producing output.
        if (frame_start)    state_nxt = SETUP;
        else if (frame_end) state_nxt = EVAL;
      end
      EVAL: begin
        eval_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Spans wrap when the box is inverted; the empty flag covers that case.
  assign span_w = {1'b0, bus.Right}  - {1'b0, bus.Left} + 12'd1;
  assign span_h = {2'b00, bus.Bottom} - {2'b00, bus.Top} + 12'd1;

  digit_grid_feature_grid_boundary #(.W(11)) u_col_bnd (
    .origin (bus.Left),
    .span   (span_w),
    .bnd    (cb_nxt)
  );

  digit_grid_feature_grid_boundary #(.W(10)) u_row_bnd (
    .origin (bus.Top),
    .span   (span_h),
    .bnd    (rb_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q   <= '0;
      right_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
      cb       <= '0;
      rb       <= '0;
      empty_q  <= 1'b1;
    end else if (setup_en) begin
      left_q   <= bus.Left;
      right_q  <= bus.Right;
      top_q    <= bus.Top;
      bottom_q <= bus.Bottom;
      cb       <= cb_nxt;
      rb       <= rb_nxt;
      empty_q  <= (bus.Right < bus.Left) || (bus.Bottom < bus.Top) ||
                  (span_w < 12'd4) || (span_h < 12'd4);
    end
  end

  always_comb begin
    col_c = '0;
    row_c = '0;
    for (int k = 0; k < GRID_N-1; k++) begin
      if (cb[k] <= bus.RGB_x_Src) col_c = col_c + IDX_W'(1);
      if (rb[k] <= bus.RGB_y_Src) row_c = row_c + IDX_W'(1);
    end
  end

  assign in_box_c = (bus.RGB_x_Src >= left_q) && (bus.RGB_x_Src <= right_q) &&
                    (bus.RGB_y_Src >= top_q)  && (bus.RGB_y_Src <= bottom_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_dark <= 1'b0;
      s1_cell <= '0;
    end else begin
      s1_vld  <= accum_en && in_box_c;
      s1_dark <= bus.RGB_Data_Src[7:0] < DARK_TH;
      s1_cell <= {row_c, col_c};
    end
  end

  // Clearing in SETUP wins over any increment still in flight from an abandoned frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        tot_cnt[i] <= '0;
        drk_cnt[i] <= '0;
      end
    end else if (setup_en) begin
      for (int i = 0; i < CELLS; i++) begin
        tot_cnt[i] <= '0;
        drk_cnt[i] <= '0;
      end
    end else if (s1_vld) begin
      tot_cnt[s1_cell] <= sat_inc(tot_cnt[s1_cell]);
      if (s1_dark) drk_cnt[s1_cell] <= sat_inc(drk_cnt[s1_cell]);
    end
  end

  always_comb begin
    feat_c = '0;
    for (int i = 0; i < CELLS; i++) begin
      feat_c[i] = (drk_cnt[i] >= (tot_cnt[i] >> 2)) && (tot_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Feature       <= '0;
      bus.Feature_Valid <= 1'b0;
      bus.Feature_Empty <= 1'b1;
    end else begin
      bus.Feature_Valid <= eval_en;
      if (eval_en) begin
        bus.Feature       <= empty_q ? '0 : feat_c;
        bus.Feature_Empty <= empty_q;
      end
    end
  end

endmodule

// File: tb/tb_digit_grid_feature.sv
// Randomized and directed bench for digit_grid_feature against a per-pixel cell-count model.
`timescale 1ns/1ps
module tb_digit_grid_feature;
  import digit_grid_feature_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digit_grid_feature_if bus();

  digit_grid_feature dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk;
  int n_pass;
  int vld_cnt;

  int m_l, m_r, m_t, m_b;
  int m_tot [16];
  int m_drk [16];
  bit m_active;
  logic [15:0] last_feat;

  int xs[$];
  int ys[$];

  always @(negedge clk) if (bus.Feature_Valid === 1'b1) vld_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: cell from the quarter-span rule, counted per pixel inside the latched box.
  task automatic model_pixel(input int x, input int y, input bit dark);
    int w, h, c, r;
    if (x < m_l || x > m_r || y < m_t || y > m_b) return;
    w = m_r - m_l + 1;
    h = m_b - m_t + 1;
    c = 0;
    r = 0;
    for (int k = 1; k < 4; k++) begin
      if (x >= m_l + (k * w) / 4) c++;
      if (y >= m_t + (k * h) / 4) r++;
    end
    m_tot[r*4+c]++;
    if (dark) m_drk[r*4+c]++;
  endtask

  task automatic put(input int x, input int y, input bit dark);
    logic [7:0] blue;
    if (dark) blue = ($urandom_range(0, 3) == 0) ? 8'd199 : 8'($urandom_range(0, 199));
    else      blue = ($urandom_range(0, 3) == 0) ? 8'd200 : 8'($urandom_range(200, 255));
    bus.RGB_x_Src    = 11'(x);
    bus.RGB_y_Src    = 10'(y);
    bus.RGB_Data_Src = {16'($urandom), blue};
    if (m_active) model_pixel(x, y, dark);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_axis(input int lo, input int hi, input int step, input bit is_x);
    int v[$];
    v.push_back(lo - 1);
    v.push_back(lo);
    v.push_back(hi);
    v.push_back(hi + 1);
    if (hi >= lo) begin
      for (int k = 1; k < 4; k++) begin
        int bd;
        bd = lo + (k * (hi - lo + 1)) / 4;
        v.push_back(bd - 1);
        v.push_back(bd);
      end
      for (int p = lo + 1; p < hi; p += step) v.push_back(p);
    end
    if (is_x) xs = v;
    else      ys = v;
  endtask

  task automatic frame_begin(input int l, input int r, input int t, input int b,
                             input int sx, input int sy);
    bus.Left   = 11'(l);
    bus.Right  = 11'(r);
    bus.Top    = 10'(t);
    bus.Bottom = 10'(b);
    m_active = 1'b0;
    put(0, 0, 1'b0);
    put(1, 0, 1'b0);
    m_l = l; m_r = r; m_t = t; m_b = b;
    for (int i = 0; i < 16; i++) begin
      m_tot[i] = 0;
      m_drk[i] = 0;
    end
    fill_axis(l, r, sx, 1'b1);
    fill_axis(t, b, sy, 1'b0);
    m_active = 1'b1;
  endtask

  // mode 0: all dark, 1: dark where x<640, 2: dark with probability pct %
  task automatic feed(input int mode, input int pct, input int limit, input bit perturb);
    int n;
    n = 0;
    for (int j = 0; j < ys.size(); j++) begin
      for (int i = 0; i < xs.size(); i++) begin
        bit dark;
        if (n >= limit) return;
        case (mode)
          0:       dark = 1'b1;
          1:       dark = (xs[i] < 640);
          default: dark = (int'($urandom_range(0, 99)) < pct);
        endcase
        if (perturb && $urandom_range(0, 31) == 0) begin
          bus.Left   = 11'($urandom);
          bus.Right  = 11'($urandom);
          bus.Top    = 10'($urandom);
          bus.Bottom = 10'($urandom);
        end
        put(xs[i], ys[j], dark);
        n++;
      end
    end
  endtask

  task automatic end_frame(input string tag);
    logic [15:0] ef;
    bit          empty;
    int          v0;
    m_active = 1'b0;
    empty = (m_r < m_l) || (m_b < m_t) || (m_r - m_l + 1 < 4) || (m_b - m_t + 1 < 4);
    ef = '0;
    if (!empty) begin
      for (int i = 0; i < 16; i++) begin
        if (m_tot[i] != 0 && m_drk[i] >= m_tot[i] / 4) ef[i] = 1'b1;
      end
    end
    v0 = vld_cnt;
    put(int'(END_X_DEF), int'(END_Y_DEF), 1'b0);
    chk({tag, "_vld_early"}, 32'(bus.Feature_Valid), 32'd0);
    put(5, 5, 1'b0);
    chk({tag, "_vld"},   32'(bus.Feature_Valid), 32'd1);
    chk({tag, "_feat"},  32'(bus.Feature), 32'(ef));
    chk({tag, "_empty"}, 32'(bus.Feature_Empty), 32'(empty));
    put(5, 5, 1'b0);
    chk({tag, "_pulses"}, 32'(vld_cnt - v0), 32'd1);
    chk({tag, "_hold"},   32'(bus.Feature), 32'(ef));
    last_feat = ef;
  endtask

  initial begin
    int v0;
    int cnt;
    n_chk    = 0;
    n_pass   = 0;
    vld_cnt  = 0;
    m_active = 1'b0;
    last_feat = '0;
    rst = 1'b1;
    bus.RGB_x_Src    = 11'd5;
    bus.RGB_y_Src    = 10'd5;
    bus.RGB_Data_Src = '0;
    bus.Left = '0; bus.Right = '0; bus.Top = '0; bus.Bottom = '0;
    #2;
    chk("rst_feat",  32'(bus.Feature), 32'd0);
    chk("rst_vld",   32'(bus.Feature_Valid), 32'd0);
    chk("rst_empty", 32'(bus.Feature_Empty), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    frame_begin(440, 839, 120, 599, 20, 24);
    feed(0, 0, 1 << 30, 1'b0);
    end_frame("dark");
    chk("dark_const", 32'(bus.Feature), 32'h0000_FFFF);
    chk("dark_nonempty", 32'(bus.Feature_Empty), 32'd0);

    frame_begin(440, 839, 120, 599, 20, 24);
    feed(1, 0, 1 << 30, 1'b0);
    end_frame("half");
    chk("half_const", 32'(bus.Feature), 32'h0000_3333);

    frame_begin(500, 499, 120, 599, 20, 24);
    feed(0, 0, 1 << 30, 1'b0);
    end_frame("degen");
    chk("degen_const", 32'(bus.Feature), 32'd0);
    chk("degen_empty", 32'(bus.Feature_Empty), 32'd1);

    // Reset in the middle of an accumulating frame, after a non-zero result.
    frame_begin(440, 839, 120, 599, 20, 24);
    feed(1, 0, 1 << 30, 1'b0);
    end_frame("pre_rst");
    frame_begin(440, 839, 120, 599, 20, 24);
    feed(0, 0, 60, 1'b0);
    m_active = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_feat",  32'(bus.Feature), 32'd0);
    chk("midrst_vld",   32'(bus.Feature_Valid), 32'd0);
    chk("midrst_empty", 32'(bus.Feature_Empty), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_begin(300, 699, 200, 599, 16, 16);
    feed(2, 30, 1 << 30, 1'b0);
    end_frame("post_rst");

    // Truncated frame: restart before END must not emit anything.
    frame_begin(440, 839, 120, 599, 20, 24);
    feed(0, 0, 100, 1'b0);
    v0 = vld_cnt;
    chk("abort_hold", 32'(bus.Feature), 32'(last_feat));
    frame_begin(200, 520, 50, 400, 10, 10);
    feed(1, 0, 1 << 30, 1'b0);
    chk("abort_novld", 32'(vld_cnt - v0), 32'd0);
    end_frame("abort_next");

    // 100x120 cells: 2880/12000 dark stays clear, 3000/12000 sets the bit.
    frame_begin(440, 839, 120, 599, 20, 24);
    cnt = 0;
    for (int y = 120; y <= 239; y++)
      for (int x = 440; x <= 539; x++) begin
        put(x, y, cnt < 2880);
        cnt++;
      end
    cnt = 0;
    for (int y = 120; y <= 239; y++)
      for (int x = 540; x <= 639; x++) begin
        put(x, y, cnt < 3000);
        cnt++;
      end
    end_frame("thr");
    chk("thr_const", 32'(bus.Feature), 32'h0000_0002);

    for (int f = 0; f < 10; f++) begin
      int l, r, t, b, w, h, sx, sy, pct;
      l = int'($urandom_range(4, 700));
      w = int'($urandom_range(0, 400));
      r = l + w - 1;
      if ($urandom_range(0, 7) == 0) r = l - int'($urandom_range(1, 3));
      t = int'($urandom_range(4, 480));
      h = int'($urandom_range(0, 400));
      b = t + h - 1;
      sx = (w / 12 > 1) ? w / 12 : 1;
      sy = (h / 12 > 1) ? h / 12 : 1;
      case ($urandom_range(0, 3))
        0:       pct = 10;
        1:       pct = 25;
        2:       pct = 40;
        default: pct = 90;
      endcase
      frame_begin(l, r, t, b, sx, sy);
      feed(2, pct, 1 << 30, 1'b1);
      end_frame($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
